// File: rtl/median_frame_collector_pkg.sv
// Shared types and default geometry for the median filter sink path.
// Holds the collector state encoding and image/pixel constants used by the filter top.
package median_frame_collector_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_W      = 256;
  localparam int DEF_IMG_H      = 256;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/median_frame_collector_if.sv
// Pixel stream in / frame-buffer write port out, bundled for the collector.
interface median_frame_collector_if
  import median_frame_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // master: pixel source that also observes the frame-buffer writes
  modport master (
    output pix_in,
    output pix_valid,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // slave: the collector
  modport slave (
    input  pix_in,
    input  pix_valid,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/median_frame_collector_raster_counter.sv
// Raster position tracker: col/row plus a running linear address, with a terminal flag on the last pixel.
// Zero latency on the flag; advances one position per inc, no backpressure.
module raster_counter
  import median_frame_collector_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int COL_W = width_of(IMG_W);
  localparam int ROW_W = width_of(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_wrap;

  assign col_wrap = (col == COL_MAX);
  assign last     = col_wrap && (row == ROW_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clr) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (inc) begin
      addr <= addr + ADDR_WIDTH'(1);
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/median_frame_collector.sv
// Rebuilds a raster frame from the filter's valid-qualified pixel stream into a frame-buffer write port.
// One-cycle write latency, one pixel per clock, no backpressure; reports done, overrun and stall timeout.
module median_frame_collector
  import median_frame_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  median_frame_collector_if.slave bus,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic                    timeout,
  output logic [ADDR_WIDTH:0]     pix_count
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int STALL_W = width_of(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  if ((longint'(1) << ADDR_WIDTH) < longint'(IMG_W) * longint'(IMG_H)) begin : g_addr_check
    $error("ADDR_WIDTH too narrow for IMG_W*IMG_H");
  end

  state_t                state, state_nxt;
  logic                  cap;
  logic                  clr;
  logic                  stall_inc;
  logic                  to_set;
  logic                  ov_set;
  logic [STALL_W-1:0]    stall_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last;
  logic [DATA_WIDTH-1:0] pix;

  assign pix = bus.pix_in;

  raster_counter #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (cap),
    .addr  (addr),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start wins over a coincident valid in IDLE/DONE: that pixel is dropped.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    clr       = 1'b0;
    stall_inc = 1'b0;
    to_set    = 1'b0;
    ov_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.pix_valid) begin
          cap = 1'b1;
          if (last) state_nxt = DONE;
        end else if (stall_cnt == STALL_LAST) begin
          to_set    = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_inc = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = COLLECT;
        end else if (bus.pix_valid) begin
          ov_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
      pix_count   <= '0;
      stall_cnt   <= '0;
    end else begin
      bus.wr_en  <= cap;
      frame_done <= cap && last;
      busy       <= (state_nxt == COLLECT);
      if (cap) begin
        bus.wr_addr <= addr;
        bus.wr_data <= pix;
        pix_count   <= pix_count + CNT_W'(1);
        stall_cnt   <= '0;
      end
      if (stall_inc) stall_cnt <= stall_cnt + STALL_W'(1);
      if (to_set)    timeout   <= 1'b1;
      if (ov_set)    overrun   <= 1'b1;
      if (clr) begin
        pix_count <= '0;
        stall_cnt <= '0;
        overrun   <= 1'b0;
        timeout   <= 1'b0;
      end
    end
  end

endmodule
